// File: rtl/spram_arb_pkg.sv
// Shared types for the single-port RAM arbiter.
// State encoding and owner constants.
package spram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD1,
    RD2
  } spram_arb_state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/spram_rr_arb.sv
// Two-way grant selection for the RAM arbiter.
// SPRAM_ARB_RR_EN selects round-robin; otherwise A has fixed priority.
module spram_rr_arb
  import spram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
`ifdef SPRAM_ARB_RR_EN
  input  logic last,
`endif
  output logic valid,
  output logic win
);

  always_comb begin
    valid = req_a | req_b;
    win   = OWN_A;
    unique case (1'b1)
      (req_a && req_b): begin
`ifdef SPRAM_ARB_RR_EN
        win = (last == OWN_A) ? OWN_B : OWN_A;
`else
        win = OWN_A;
`endif
      end
      (req_b && !req_a): win = OWN_B;
      default:           win = OWN_A;
    endcase
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between requesters A and B.
// Tie-break set by SPRAM_ARB_RR_EN (round-robin) or fixed A priority.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  spram_arb_state_t state, state_n;

  logic                  owner, owner_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  cs_n, we_n, oe_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  gnt_a_n, gnt_b_n;
  logic                  rvalid_a_n, rvalid_b_n;
  logic [DATA_WIDTH-1:0] rdata_a_n, rdata_b_n;
  logic                  arb_valid, win;

`ifdef SPRAM_ARB_RR_EN
  logic last_q;
`endif

  spram_rr_arb u_arb (
    .req_a (req_a),
    .req_b (req_b),
`ifdef SPRAM_ARB_RR_EN
    .last  (last_q),
`endif
    .valid (arb_valid),
    .win   (win)
  );

  // Only WR drives the bus; RD1 keeps oe low as the turnaround cycle.
  assign ram_data = (state == WR) ? wdata_q
                                  : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_A;
      wdata_q  <= '0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_addr <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
`ifdef SPRAM_ARB_RR_EN
      last_q   <= OWN_B;
`endif
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      wdata_q  <= wdata_n;
      ram_cs   <= cs_n;
      ram_we   <= we_n;
      ram_oe   <= oe_n;
      ram_addr <= addr_n;
      gnt_a    <= gnt_a_n;
      gnt_b    <= gnt_b_n;
      rvalid_a <= rvalid_a_n;
      rvalid_b <= rvalid_b_n;
      rdata_a  <= rdata_a_n;
      rdata_b  <= rdata_b_n;
`ifdef SPRAM_ARB_RR_EN
      if (gnt_a_n || gnt_b_n)
        last_q <= win;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    wdata_n    = wdata_q;
    cs_n       = ram_cs;
    we_n       = ram_we;
    oe_n       = ram_oe;
    addr_n     = ram_addr;
    gnt_a_n    = 1'b0;
    gnt_b_n    = 1'b0;
    rvalid_a_n = 1'b0;
    rvalid_b_n = 1'b0;
    rdata_a_n  = rdata_a;
    rdata_b_n  = rdata_b;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          owner_n = win;
          cs_n    = 1'b1;
          oe_n    = 1'b0;
          if (win == OWN_B) begin
            we_n    = we_b;
            addr_n  = addr_b;
            wdata_n = wdata_b;
            gnt_b_n = 1'b1;
          end else begin
            we_n    = we_a;
            addr_n  = addr_a;
            wdata_n = wdata_a;
            gnt_a_n = 1'b1;
          end
          state_n = we_n ? WR : RD1;
        end
      end
      WR: begin
        state_n = IDLE;
        cs_n    = 1'b0;
        we_n    = 1'b0;
      end
      RD1: begin
        state_n = RD2;
        oe_n    = 1'b1;
      end
      RD2: begin
        state_n = IDLE;
        cs_n    = 1'b0;
        oe_n    = 1'b0;
        if (owner == OWN_B) begin
          rdata_b_n  = ram_data;
          rvalid_b_n = 1'b1;
        end else begin
          rdata_a_n  = ram_data;
          rvalid_a_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
